// File: rtl/msg_schedule_if.sv
// Handshake bundle between the message-schedule expander, its block source and the
// compression core that consumes the W stream.
interface msg_schedule_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_out;
  logic [5:0]  t_idx;
  logic        busy;
  logic        block_done;

  modport slave (
    input  in_valid, in_word, w_ready,
    output in_ready, w_valid, w_out, t_idx, busy, block_done
  );

  modport master (
    output in_valid, in_word, w_ready,
    input  in_ready, w_valid, w_out, t_idx, busy, block_done
  );
endinterface

// File: rtl/msg_schedule.sv
// SHA-256 message-schedule expander: loads 16 words, then streams W[0..ROUNDS-1]
// from a 16-entry sliding window, expanding one new word per accepted output.
module msg_schedule #(
  parameter int unsigned ROUNDS      = 64,
  parameter int unsigned BLOCK_WORDS = 16
) (
  input logic           clk,
  input logic           reset,
  msg_schedule_if.slave bus
);

  localparam logic [5:0] LastLoad  = 6'(BLOCK_WORDS - 1);
  localparam logic [5:0] LastRound = 6'(ROUNDS - 1);

  typedef enum logic [0:0] {StLoad, StEmit} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Computed on every shift; the last 16 results fall off the end unused.
  assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    done_d  = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (bus.in_valid) begin
          win_d[cnt_q[3:0]] = bus.in_word;
          if (cnt_q == LastLoad) begin
            cnt_d   = '0;
            state_d = StEmit;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      StEmit: begin
        if (bus.w_ready) begin
          for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[15] = w_new;
          if (cnt_q == LastRound) begin
            cnt_d   = '0;
            state_d = StLoad;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  // Outputs decode straight from registers, so they carry no combinational input paths.
  assign bus.in_ready   = (state_q == StLoad);
  assign bus.w_valid    = (state_q == StEmit);
  assign bus.busy       = (state_q == StEmit);
  assign bus.w_out      = win_q[0];
  assign bus.t_idx      = cnt_q;
  assign bus.block_done = done_q;

endmodule
